// File: rtl/mult_arb.sv
// -----------------------------------------------------------------------------
// mult_arb
//    Round-robin arbiter in front of one shared, pipelined 8x8 signed
//    multiplier. At most one requester is granted per cycle. The winner's
//    operands go to the multiplier combinationally. An ID pipeline, matched to
//    the multiplier latency, tracks who owns each in-flight product so that
//    every result returns to its requester with a valid strobe.
//
//    Optional feature macro: MULT_ARB_PERF_EN
//       defined   : adds the busy_cnt port, a saturating count of busy cycles
//       undefined : no busy_cnt port and no counter; all else is identical
//
// Ports
//    clk        in   clock, every register updates on posedge
//    rst        in   synchronous reset, active-high
//    en         in   1 = grants allowed; 0 = no new grants, in-flight ops drain
//    req_valid  in   [NREQ]    per-requester request
//    req_ready  out  [NREQ]    per-requester grant, one-hot or zero (comb)
//    req_a      in   [NREQ*8]  multiplicands, requester i at [8i+7:8i]
//    req_b      in   [NREQ*8]  multipliers, same packing
//    mult_a     out  [8]       to multiplier input a (8'h00 when idle)
//    mult_b     out  [8]       to multiplier input b (8'h00 when idle)
//    mult_out   in   [16]      from multiplier output
//    rsp_valid  out            product valid this cycle
//    rsp_id     out  [IDW]     requester that owns rsp_data
//    rsp_data   out  [16]      signed product
//    busy       out            some operation is still in flight
//    busy_cnt   out  [16]      cycles with busy=1 (MULT_ARB_PERF_EN only)
// -----------------------------------------------------------------------------
module mult_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int LAT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   output logic [7:0]        mult_a,
   output logic [7:0]        mult_b,
   input  logic [15:0]       mult_out,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [15:0]       rsp_data,
   output logic              busy
`ifdef MULT_ARB_PERF_EN
   ,
   output logic [15:0]       busy_cnt
`endif
);

   logic [IDW-1:0]          ptr_q, ptr_d;
   logic                    found;
   logic [IDW-1:0]          winner;
   int                      scan_idx;
   logic                    grant;

   // One stage per multiplier latency cycle; stage 0 is written on the grant.
   logic [LAT-1:0]          v_q;
   logic [LAT-1:0][IDW-1:0] id_q;

   // Rotating priority scan starting at ptr_q; the first requester found wins.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = int'(ptr_q) + k;
         if (scan_idx >= NREQ) begin
            scan_idx = scan_idx - NREQ;
         end
         if (!found && req_valid[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx[IDW-1:0];
         end
      end
   end

   // A grant is always a handshake: the winner is guaranteed to be requesting.
   assign grant = found & en & ~rst;

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      mult_a = 8'h00;
      mult_b = 8'h00;
      if (grant) begin
         mult_a = req_a[int'(winner)*8 +: 8];
         mult_b = req_b[int'(winner)*8 +: 8];
      end
   end

   // Pointer moves to one past the winner, so an idle requester is skipped
   // and a lone requester wins every cycle.
   always_comb begin
      ptr_d = ptr_q;
      if (grant) begin
         if (winner == IDW'(NREQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = winner + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Reset clears every valid, so products in flight at reset are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q  <= '0;
         id_q <= '0;
      end else begin
         v_q[0]  <= grant;
         id_q[0] <= winner;
         for (int s = 1; s < LAT; s++) begin
            v_q[s]  <= v_q[s-1];
            id_q[s] <= id_q[s-1];
         end
      end
   end

   assign rsp_valid = v_q[LAT-1];
   assign rsp_id    = id_q[LAT-1];
   assign rsp_data  = mult_out;
   assign busy      = |v_q;

`ifdef MULT_ARB_PERF_EN
   logic [15:0] busy_cnt_q, busy_cnt_d;

   always_comb begin
      busy_cnt_d = busy_cnt_q;
      if (busy && (busy_cnt_q != 16'hFFFF)) begin
         busy_cnt_d = busy_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_cnt_q <= 16'd0;
      end else begin
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_mult_arb.sv
module tb_mult_arb;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [7:0]  mult_a;
   logic [7:0]  mult_b;
   logic [15:0] mult_out;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic        busy;
`ifdef MULT_ARB_PERF_EN
   logic [15:0] busy_cnt;
`endif

   mult_arb #(.NREQ(4), .IDW(2), .LAT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mult_a    (mult_a),
      .mult_b    (mult_b),
      .mult_out  (mult_out),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
`ifdef MULT_ARB_PERF_EN
      ,
      .busy_cnt  (busy_cnt)
`endif
   );

   // Two-register signed multiplier model: product appears two edges after
   // the operands are presented.
   logic [7:0] ma_q, mb_q;
   always @(posedge clk) begin
      ma_q     <= mult_a;
      mb_q     <= mult_b;
      mult_out <= 16'($signed(ma_q) * $signed(mb_q));
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      logic [15:0] data;
      int          due;
   } exp_t;
   exp_t sbq[$];

   int checks   = 0;
   int failures = 0;

   // Monitor: pops the scoreboard whenever the DUT presents a response.
   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
         e = sbq.pop_front();
         checks++;
         failures++;
         $display("FAIL rsp_missing: id=%0d due cycle %0d not seen by cycle %0d", e.id, e.due, cyc);
      end
      if (rsp_valid) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected: got id=%0d data=%h at cycle %0d, expected none", rsp_id, rsp_data, cyc);
         end else begin
            e = sbq.pop_front();
            if (e.due != cyc || int'(rsp_id) != e.id || rsp_data !== e.data) begin
               failures++;
               $display("FAIL rsp_match: got id=%0d data=%h cycle=%0d, expected id=%0d data=%h cycle=%0d",
                        rsp_id, rsp_data, cyc, e.id, e.data, e.due);
            end
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic [3:0] rv,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] exp_rdy, input int exp_id,
                       input logic [15:0] exp_data, input bit push,
                       input int exp_busy, input string name);
      exp_t x;
      rst       = r;
      en        = e;
      req_valid = rv;
      req_a     = a;
      req_b     = b;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_rdy) begin
         failures++;
         $display("FAIL %s ready: got %b expected %b (cycle %0d)", name, req_ready, exp_rdy, cyc);
      end
      if (exp_busy >= 0) begin
         checks++;
         if (busy !== exp_busy[0]) begin
            failures++;
            $display("FAIL %s busy: got %b expected %0d (cycle %0d)", name, busy, exp_busy, cyc);
         end
      end
      if (push) begin
         x.id   = exp_id;
         x.data = exp_data;
         x.due  = cyc + 2;
         sbq.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] A4 = 32'h281E140A;  // 40,30,20,10
   localparam logic [31:0] B4 = 32'hFCFDFEFF;  // -4,-3,-2,-1

   initial begin
      rst = 1'b1; en = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0;

      // reset held with all requesting
      for (int i = 0; i < 3; i++)
         step(1, 1, 4'hF, 32'h0, 32'h0, 4'h0, 0, 16'h0, 0, 0, "reset_hold");

      // single requester 0: 3*5
      step(0, 1, 4'h1, 32'h00000003, 32'h00000005, 4'h1, 0, 16'h000F, 1, -1, "req0_3x5");
      step(0, 1, 4'h0, 32'h0, 32'h0, 4'h0, 0, 16'h0, 0, 1, "drain0_a");
      step(0, 1, 4'h0, 32'h0, 32'h0, 4'h0, 0, 16'h0, 0, 1, "drain0_b");
      step(0, 1, 4'h0, 32'h0, 32'h0, 4'h0, 0, 16'h0, 0, 0, "drain0_c");

      // requester 2 alone, back-to-back with changing signed operands
      step(0, 1, 4'h4, 32'h00FD0000, 32'h00050000, 4'h4, 2, 16'hFFF1, 1, -1, "req2_m3x5");
      step(0, 1, 4'h4, 32'h00800000, 32'h00800000, 4'h4, 2, 16'h4000, 1, -1, "req2_m128sq");
      step(0, 1, 4'h4, 32'h007F0000, 32'h00800000, 4'h4, 2, 16'hC080, 1, -1, "req2_127xm128");
      for (int i = 0; i < 3; i++)
         step(0, 1, 4'h0, 32'h0, 32'h0, 4'h0, 0, 16'h0, 0, -1, "drain2");
      step(0, 1, 4'h0, 32'h0, 32'h0, 4'h0, 0, 16'h0, 0, 0, "idle2");

      // reset pointer, then all requesting for 8 cycles
      step(1, 1, 4'hF, 32'h0, 32'h0, 4'h0, 0, 16'h0, 0, 0, "rst_ptr");
      step(0, 1, 4'hF, A4, B4, 4'h1, 0, 16'hFFF6, 1, -1, "rr0");
      step(0, 1, 4'hF, A4, B4, 4'h2, 1, 16'hFFD8, 1, -1, "rr1");
      step(0, 1, 4'hF, A4, B4, 4'h4, 2, 16'hFFA6, 1, -1, "rr2");
      step(0, 1, 4'hF, A4, B4, 4'h8, 3, 16'hFF60, 1, -1, "rr3");
      step(0, 1, 4'hF, A4, B4, 4'h1, 0, 16'hFFF6, 1, -1, "rr4");
      step(0, 1, 4'hF, A4, B4, 4'h2, 1, 16'hFFD8, 1, -1, "rr5");
      step(0, 1, 4'hF, A4, B4, 4'h4, 2, 16'hFFA6, 1, -1, "rr6");
      step(0, 1, 4'hF, A4, B4, 4'h8, 3, 16'hFF60, 1, 1, "rr7");

      // disable with two ops in flight: no grants, drain, busy drops
      step(0, 0, 4'hF, A4, B4, 4'h0, 0, 16'h0, 0, 1, "en_off_a");
      step(0, 0, 4'hF, A4, B4, 4'h0, 0, 16'h0, 0, 1, "en_off_b");
      step(0, 0, 4'hF, A4, B4, 4'h0, 0, 16'h0, 0, 0, "en_off_c");

      // grant to 2 (ptr is 0), then reset: that product must never appear
      step(0, 1, 4'h4, A4, B4, 4'h4, 2, 16'h0, 0, -1, "pre_rst_grant");
      step(1, 1, 4'hF, A4, B4, 4'h0, 0, 16'h0, 0, -1, "rst_pulse");
      step(0, 1, 4'hF, A4, B4, 4'h1, 0, 16'hFFF6, 1, 0, "post_rst_grant");
      for (int i = 0; i < 3; i++)
         step(0, 1, 4'h0, 32'h0, 32'h0, 4'h0, 0, 16'h0, 0, -1, "final_drain");
      step(0, 1, 4'h0, 32'h0, 32'h0, 4'h0, 0, 16'h0, 0, 0, "final_idle");

      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL sb_empty: %0d responses outstanding, expected 0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
